uart_receiver_framed: RTL and testbench

UART_RECEIVER_FRAMED -- requirements
Module: uart_receiver_framed

---
 rtl/uart_receiver_framed.sv | 185 ++++++++++++++++++
 tb/tb_uart_receiver_framed.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_framed.sv
// Framed UART receiver: 2-flop synchronizer, 3-sample majority bit decisions,
// optional parity, 1 or 2 stop bits, break/overrun pulses and a small frame FIFO.
module uart_receiver_framed #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  break_detect,
  output logic                  overrun
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BIW = $clog2(DATA_WIDTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_WIDTH + 2;
  localparam logic [CW-1:0] MID_LO = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(CPB / 2);
  localparam logic [CW-1:0] MID_HI = CW'(CPB / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(CPB - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  logic                  sync_reg, rx_s;
  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [BIW-1:0]        bit_idx_reg;
  logic [1:0]            samp_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_err_reg, frm_err_reg, par_bit_reg;

  logic majority, decide, bit_end, par_expected;
  logic frame_done, frame_ferr, is_break;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_reg <= serial_in;
      rx_s     <= sync_reg;
    end
  end

  // Two early samples are held; the third is the live rx_s at the decision cycle.
  assign majority     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
  assign decide       = (cnt_reg == MID_HI);
  assign bit_end      = (cnt_reg == LAST);
  assign par_expected = (PARITY == 2) ? ^shift_reg : ~^shift_reg;
  assign frame_done   = (state_reg == STOP) && decide && (bit_idx_reg == BIW'(STOP_BITS - 1));
  assign frame_ferr   = frm_err_reg | ~majority;
  assign is_break     = (shift_reg == '0) && !par_bit_reg && frame_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      samp_reg    <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      if (cnt_reg == MID_LO || cnt_reg == MID)
        samp_reg <= {samp_reg[0], rx_s};
      case (state_reg)
        IDLE: begin
          // The detection cycle is counter 0 of the start bit.
          if (!rx_s) begin
            state_reg   <= START;
            cnt_reg     <= CW'(1);
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            par_bit_reg <= 1'b0;
          end
        end
        START: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (decide && majority) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (bit_end) begin
            state_reg   <= DATA;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (decide)
            shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg == BIW'(DATA_WIDTH - 1)) begin
              bit_idx_reg <= '0;
              state_reg   <= (PARITY != 0) ? PARITY_BIT : STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + BIW'(1);
            end
          end
        end
        PARITY_BIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (decide) begin
            par_bit_reg <= majority;
            par_err_reg <= (majority != par_expected);
          end
          if (bit_end) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= STOP;
          end
        end
        STOP: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (decide) begin
            if (!majority)
              frm_err_reg <= 1'b1;
            if (bit_idx_reg == BIW'(STOP_BITS - 1)) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end else if (bit_end) begin
            cnt_reg     <= '0;
            bit_idx_reg <= bit_idx_reg + BIW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0] head;
  logic          fifo_empty, fifo_full, do_pop, do_push;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop     = !fifo_empty && data_out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for this frame.
  assign do_push    = frame_done && !is_break && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg[AW-1:0]] <= {shift_reg, par_err_reg, frame_ferr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      break_detect <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      break_detect <= frame_done && is_break;
      overrun      <= frame_done && !is_break && fifo_full && !do_pop;
    end
  end

  assign head           = mem[rd_ptr_reg[AW-1:0]];
  assign data_out_valid = !fifo_empty;
  assign data_out       = head[EW-1:2];
  assign parity_error   = data_out_valid & head[1];
  assign frame_error    = data_out_valid & head[0];
endmodule

// File: tb/tb_uart_receiver_framed.sv
// Bench for uart_receiver_framed: frame-level model of the receive FIFO and
// pulses, compared every cycle, plus directed literal checks and random frames.
module tb_uart_receiver_framed;
  localparam int CLK_F = 1_000_000;
  localparam int BAUD  = 100_000;
  localparam int CPB   = CLK_F / BAUD;
  localparam int DW    = 8;
  localparam int PAR   = 2;
  localparam int STOPB = 1;
  localparam int DEPTH = 4;

  typedef struct packed {logic [DW-1:0] d; logic pe; logic fe;} entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;
  logic data_out_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic data_out_valid, parity_error, frame_error, break_detect, overrun;

  uart_receiver_framed #(
    .CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .DATA_WIDTH(DW),
    .PARITY(PAR), .STOP_BITS(STOPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .parity_error(parity_error),
    .frame_error(frame_error), .break_detect(break_detect), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;
  bit rand_mode = 0;
  logic ready_force = 1'b1;

  entry_t mq[$];
  entry_t pend_entry;
  bit pend_valid = 0;
  bit pend_brk = 0;
  int pend_done = 0;
  bit exp_break = 0;
  bit exp_ovr = 0;
  int brk_seen = 0;
  int ovr_seen = 0;
  int valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver: settles shortly after each falling edge.
  initial forever begin
    @(negedge clk);
    #1;
    data_out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Frame-level reference: a completed frame lands at its known completion edge.
  initial forever begin
    bit pop, push;
    @(posedge clk);
    cyc++;
    exp_break = 0;
    exp_ovr = 0;
    if (reset) begin
      mq.delete();
      pend_valid = 0;
    end else begin
      pop = (mq.size() > 0) && data_out_ready;
      push = 0;
      if (pend_valid && pend_done == cyc) begin
        pend_valid = 0;
        if (pend_brk) exp_break = 1;
        else if (mq.size() == DEPTH && !pop) exp_ovr = 1;
        else push = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pend_entry);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      check("valid", data_out_valid, mq.size() > 0);
      check("break_detect", break_detect, exp_break);
      check("overrun", overrun, exp_ovr);
      if (mq.size() > 0) begin
        check("data_out", data_out, mq[0].d);
        check("parity_error", parity_error, mq[0].pe);
        check("frame_error", frame_error, mq[0].fe);
      end else begin
        check("parity_error_idle", parity_error, 0);
        check("frame_error_idle", frame_error, 0);
      end
      brk_seen += int'(break_detect);
      ovr_seen += int'(overrun);
      valid_cycles += int'(data_out_valid && data_out_ready);
    end
  end

  // Drives one frame starting at the next falling edge; glitch_pos/abort_at are
  // line-cycle offsets from the start bit (-1 = none).
  task automatic send_frame(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop,
                            input int glitch_pos, input int abort_at);
    logic line [0:15];
    logic pb;
    int n;
    n = 0;
    pb = 1'b0;
    line[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin line[n] = d[i]; n++; end
    if (PAR != 0) begin
      pb = ((PAR == 2) ? ^d : ~^d) ^ bad_par;
      line[n] = pb; n++;
    end
    for (int s = 0; s < STOPB; s++) begin line[n] = !bad_stop; n++; end
    @(negedge clk);
    pend_entry = {d, (PAR != 0) && bad_par, bad_stop};
    pend_brk = (d == '0) && (pb == 1'b0) && bad_stop;
    pend_done = cyc + 3 + (n - 1) * CPB + CPB / 2 + 1;
    pend_valid = 1;
    for (int j = 0; j < n * CPB; j++) begin
      if (j == abort_at) begin
        reset = 1'b1;
        serial_in = 1'b1;
        return;
      end
      serial_in = line[j / CPB] ^ (j == glitch_pos);
      @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (2 * CPB + $urandom_range(0, CPB)) @(negedge clk);
  endtask

  task automatic pop_expect(input logic [DW-1:0] d, input logic pe, input logic fe);
    check("lit_valid", data_out_valid, 1);
    check("lit_data", data_out, d);
    check("lit_parity_error", parity_error, pe);
    check("lit_frame_error", frame_error, fe);
    ready_force = 1'b1;
    @(negedge clk);
    ready_force = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int brk0, ovr0, val0;
    repeat (3) @(negedge clk);
    started = 1;
    check("reset_valid", data_out_valid, 0);
    check("reset_break", break_detect, 0);
    check("reset_overrun", overrun, 0);
    check("reset_perr", parity_error, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 with ready high: exactly one accepted cycle.
    val0 = valid_cycles;
    send_frame(8'hA5, 0, 0, -1, -1);
    check("a5_one_pop", valid_cycles - val0, 1);

    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h3C, 1, 0, -1, -1);
    pop_expect(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 0, 0, -1, -1);
    pop_expect(8'h3C, 1'b0, 1'b0);

    // Short low pulse is rejected; a one-cycle glitch mid data bit is voted out.
    @(negedge clk); serial_in = 1'b0;
    repeat (3) @(negedge clk); serial_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("short_low_nopush", data_out_valid, 0);
    send_frame(8'h96, 0, 0, 3 * CPB + CPB / 2, -1);
    pop_expect(8'h96, 1'b0, 1'b0);

    send_frame(8'h55, 0, 1, -1, -1);
    pop_expect(8'h55, 1'b0, 1'b1);
    brk0 = brk_seen;
    send_frame(8'h00, 0, 1, -1, -1);
    check("break_pulse_count", brk_seen - brk0, 1);
    check("break_nopush", data_out_valid, 0);

    // Fill and overflow.
    ovr0 = ovr_seen;
    for (int i = 1; i <= 5; i++) send_frame(DW'(i), 0, 0, -1, -1);
    check("overrun_count", ovr_seen - ovr0, 1);
    for (int i = 1; i <= 4; i++) pop_expect(DW'(i), 1'b0, 1'b0);
    check("drained", data_out_valid, 0);

    // Push and pop on the same edge with the FIFO full.
    for (int i = 0; i < 4; i++) send_frame(DW'(8'h11 + i), 0, 0, -1, -1);
    ovr0 = ovr_seen;
    fork
      send_frame(8'h15, 0, 0, -1, -1);
      begin
        @(negedge clk); #2;
        while (cyc != pend_done - 1) @(negedge clk);
        ready_force = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
      end
    join
    check("full_pushpop_no_overrun", ovr_seen - ovr0, 0);
    for (int i = 2; i <= 5; i++) pop_expect(DW'(8'h10 + i), 1'b0, 1'b0);

    // Reset in the middle of data bit 3, then a clean frame.
    send_frame(8'h5A, 0, 0, -1, 4 * CPB + CPB / 2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("after_reset_valid", data_out_valid, 0);
    send_frame(8'h7E, 0, 0, -1, -1);
    pop_expect(8'h7E, 1'b0, 1'b0);

    // Random frames with random consumer back-pressure.
    rand_mode = 1;
    for (int k = 0; k < 60; k++) begin
      logic [DW-1:0] d;
      int g;
      d = DW'($urandom);
      if ($urandom_range(0, 9) == 0) d = '0;
      g = ($urandom_range(0, 1) == 1) ? (1 + $urandom_range(0, DW - 1)) * CPB + $urandom_range(0, CPB - 1) : -1;
      send_frame(d, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, g, -1);
    end
    rand_mode = 0;
    ready_force = 1'b1;
    repeat (20) @(negedge clk);
    check("final_empty", data_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
